// File: rtl/fft_frame_sink.sv
// Stream sink for framed I/Q symbol bursts: checks burst length and slot/symbol sequencing,
// counts good symbols and reports the peak |I| sample. Define FFT_SINK_PEAK_EN to build the peak detector.
module fft_frame_sink #(
  parameter int DATA_NBIT = 16,
  parameter int CNT_NBIT  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           fft_num,
  input  logic                 cp_type,
  input  logic [DATA_NBIT-1:0] sink_i,
  input  logic [DATA_NBIT-1:0] sink_q,
  input  logic                 sink_h,
  input  logic                 sink_s,
  input  logic                 sink_v,
  output logic                 sym_done,
  output logic [2:0]           sym_idx,
  output logic [CNT_NBIT-1:0]  sym_total,
  output logic                 len_err,
  output logic                 hdr_err,
  output logic                 slot_err,
  output logic [11:0]          pk_idx,
  output logic [DATA_NBIT-1:0] pk_val
);

  typedef enum logic [1:0] {IDLE, ARM, COLLECT} state_e;

  state_e              state_q, state_d;
  logic [11:0]         cnt_q, cnt_d;
  logic [11:0]         len_q, len_d;
  logic                seen_q, seen_d;
  logic                fail_q, fail_d;
  logic                sym_done_q, sym_done_d;
  logic [2:0]          sym_idx_q, sym_idx_d;
  logic [CNT_NBIT-1:0] sym_total_q, sym_total_d;
  logic                len_err_q, len_err_d;
  logic                hdr_err_q, hdr_err_d;
  logic                slot_err_q, slot_err_d;

  logic        hdr_acc, burst_end, samp_acc, arm_start;
  logic [11:0] hdr_len;
  logic [2:0]  last_idx;

  always_comb begin
    hdr_len = 12'd2048;
    case (fft_num)
      2'b00:   hdr_len = 12'd2048;
      2'b01:   hdr_len = 12'd1536;
      2'b10:   hdr_len = 12'd1024;
      default: hdr_len = 12'd512;
    endcase
    last_idx = cp_type ? 3'd5 : 3'd6;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    seen_d      = seen_q;
    fail_d      = fail_q;
    sym_done_d  = 1'b0;
    sym_idx_d   = sym_idx_q;
    sym_total_d = sym_total_q;
    len_err_d   = len_err_q;
    hdr_err_d   = hdr_err_q;
    slot_err_d  = slot_err_q;
    hdr_acc     = 1'b0;
    burst_end   = 1'b0;
    samp_acc    = 1'b0;
    arm_start   = 1'b0;

    case (state_q)
      IDLE: begin
        if (sink_h) begin
          hdr_acc = 1'b1;
          state_d = ARM;
        end else if (sink_v) begin
          hdr_err_d = 1'b1;
        end
      end
      ARM: begin
        if (sink_h) begin
          hdr_err_d = 1'b1;
          hdr_acc   = 1'b1;
        end else if (sink_v) begin
          state_d   = COLLECT;
          cnt_d     = 12'd1;
          fail_d    = 1'b0;
          samp_acc  = 1'b1;
          arm_start = 1'b1;
        end else begin
          hdr_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      COLLECT: begin
        if (sink_v) begin
          if (sink_h) begin
            hdr_err_d = 1'b1;
            len_err_d = 1'b1;
            hdr_acc   = 1'b1;
            state_d   = ARM;
          end else if (cnt_q < len_q) begin
            cnt_d    = cnt_q + 12'd1;
            samp_acc = 1'b1;
          end else begin
            // overlong burst: freeze the count and poison the burst
            len_err_d = 1'b1;
            fail_d    = 1'b1;
          end
        end else begin
          burst_end = 1'b1;
          hdr_acc   = sink_h;
          state_d   = sink_h ? ARM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (burst_end) begin
      if (cnt_q == len_q && !fail_q) begin
        sym_done_d  = 1'b1;
        sym_total_d = sym_total_q + CNT_NBIT'(1);
      end else begin
        len_err_d = 1'b1;
      end
    end

    if (hdr_acc) begin
      len_d  = hdr_len;
      seen_d = 1'b1;
      if (sink_s) begin
        if (seen_q && sym_idx_q != last_idx) slot_err_d = 1'b1;
        sym_idx_d = 3'd0;
      end else begin
        if (!seen_q) slot_err_d = 1'b1;
        if (sym_idx_q == last_idx) begin
          slot_err_d = 1'b1;
          sym_idx_d  = 3'd0;
        end else begin
          sym_idx_d = sym_idx_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= 12'd2048;
      seen_q      <= 1'b0;
      fail_q      <= 1'b0;
      sym_done_q  <= 1'b0;
      sym_idx_q   <= '0;
      sym_total_q <= '0;
      len_err_q   <= 1'b0;
      hdr_err_q   <= 1'b0;
      slot_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      seen_q      <= seen_d;
      fail_q      <= fail_d;
      sym_done_q  <= sym_done_d;
      sym_idx_q   <= sym_idx_d;
      sym_total_q <= sym_total_d;
      len_err_q   <= len_err_d;
      hdr_err_q   <= hdr_err_d;
      slot_err_q  <= slot_err_d;
    end
  end

  assign sym_done  = sym_done_q;
  assign sym_idx   = sym_idx_q;
  assign sym_total = sym_total_q;
  assign len_err   = len_err_q;
  assign hdr_err   = hdr_err_q;
  assign slot_err  = slot_err_q;

`ifdef FFT_SINK_PEAK_EN
  localparam logic [DATA_NBIT-1:0] MIN_NEG = {1'b1, {(DATA_NBIT-1){1'b0}}};
  localparam logic [DATA_NBIT-1:0] MAX_POS = {1'b0, {(DATA_NBIT-1){1'b1}}};

  logic [DATA_NBIT-1:0] abs_i;
  logic [DATA_NBIT-1:0] run_max_q, run_max_d, pk_val_q, pk_val_d;
  logic [11:0]          run_idx_q, run_idx_d, pk_idx_q, pk_idx_d;

  always_comb begin
    abs_i = sink_i;
    if (sink_i[DATA_NBIT-1]) abs_i = (sink_i == MIN_NEG) ? MAX_POS : (DATA_NBIT'(0) - sink_i);
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    pk_val_d  = pk_val_q;
    pk_idx_d  = pk_idx_q;
    // first sample of a burst restarts the search; strict compare keeps the earliest tie
    if (arm_start) begin
      run_max_d = abs_i;
      run_idx_d = 12'd0;
    end else if (samp_acc && abs_i > run_max_q) begin
      run_max_d = abs_i;
      run_idx_d = cnt_q;
    end
    if (sym_done_d) begin
      pk_val_d = run_max_q;
      pk_idx_d = run_idx_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_max_q <= '0;
      run_idx_q <= '0;
      pk_val_q  <= '0;
      pk_idx_q  <= '0;
    end else begin
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      pk_val_q  <= pk_val_d;
      pk_idx_q  <= pk_idx_d;
    end
  end

  assign pk_idx = pk_idx_q;
  assign pk_val = pk_val_q;

  logic unused_in;
  assign unused_in = ^sink_q;
`else
  assign pk_idx = '0;
  assign pk_val = '0;

  logic unused_in;
  assign unused_in = ^{sink_q, sink_i, samp_acc, arm_start};
`endif

endmodule

// File: tb/tb_fft_frame_sink.sv
// Directed-sequence bench with randomized sample content, checked against a transaction-level model.
module tb_fft_frame_sink;
  localparam int DW = 16;
  localparam int CW = 16;
`ifdef FFT_SINK_PEAK_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    fft_num;
  logic          cp_type;
  logic [DW-1:0] sink_i, sink_q;
  logic          sink_h, sink_s, sink_v;
  logic          sym_done;
  logic [2:0]    sym_idx;
  logic [CW-1:0] sym_total;
  logic          len_err, hdr_err, slot_err;
  logic [11:0]   pk_idx;
  logic [DW-1:0] pk_val;

  fft_frame_sink #(.DATA_NBIT(DW), .CNT_NBIT(CW)) dut (
    .clk(clk), .reset(reset), .fft_num(fft_num), .cp_type(cp_type),
    .sink_i(sink_i), .sink_q(sink_q), .sink_h(sink_h), .sink_s(sink_s), .sink_v(sink_v),
    .sym_done(sym_done), .sym_idx(sym_idx), .sym_total(sym_total),
    .len_err(len_err), .hdr_err(hdr_err), .slot_err(slot_err),
    .pk_idx(pk_idx), .pk_val(pk_val)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int samp[2048];

  int m_done, m_idx, m_total, m_len_err, m_hdr_err, m_slot_err, m_seen, m_len, m_pk_idx, m_pk_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sym_done"},  32'(sym_done),  32'(m_done));
    chk({tag, ".sym_idx"},   32'(sym_idx),   32'(m_idx));
    chk({tag, ".sym_total"}, 32'(sym_total), 32'(m_total));
    chk({tag, ".len_err"},   32'(len_err),   32'(m_len_err));
    chk({tag, ".hdr_err"},   32'(hdr_err),   32'(m_hdr_err));
    chk({tag, ".slot_err"},  32'(slot_err),  32'(m_slot_err));
    chk({tag, ".pk_idx"},    32'(pk_idx),    PEAK ? 32'(m_pk_idx) : 32'd0);
    chk({tag, ".pk_val"},    32'(pk_val),    PEAK ? 32'(m_pk_val) : 32'd0);
  endtask

  function automatic void model_reset();
    m_done = 0; m_idx = 0; m_total = 0; m_len_err = 0; m_hdr_err = 0;
    m_slot_err = 0; m_seen = 0; m_len = 2048; m_pk_idx = 0; m_pk_val = 0;
  endfunction

  // Slot bookkeeping: a slot holds 7 (normal) or 6 (extended) symbols.
  function automatic void model_hdr(input int s);
    int last;
    last  = cp_type ? 5 : 6;
    m_len = (4 - int'(fft_num)) * 512;
    if (s != 0) begin
      if (m_seen != 0 && m_idx != last) m_slot_err = 1;
      m_idx = 0;
    end else begin
      if (m_seen == 0) m_slot_err = 1;
      if (m_idx == last) begin
        m_slot_err = 1;
        m_idx = 0;
      end else begin
        m_idx = m_idx + 1;
      end
    end
    m_seen = 1;
  endfunction

  function automatic void model_end(input int n, input int gap);
    int a, best, bidx;
    m_done = 0;
    if (gap > 0) m_hdr_err = 1;
    else if (n != m_len) m_len_err = 1;
    else begin
      m_done  = 1;
      m_total = (m_total + 1) % (1 << CW);
      best = 0; bidx = 0;
      for (int k = 0; k < n; k++) begin
        a = (samp[k] < 0) ? -samp[k] : samp[k];
        if (a > 32767) a = 32767;
        if (a > best) begin best = a; bidx = k; end
      end
      m_pk_val = best;
      m_pk_idx = bidx;
    end
  endfunction

  task automatic fill(input int n, input int amp);
    for (int k = 0; k < n; k++) samp[k] = int'($urandom_range(0, 2 * amp)) - amp;
  endtask

  // header, `gap` idle clocks, n valid samples, then valid drops
  task automatic xact(input string tag, input int s, input int n, input int gap);
    @(negedge clk);
    sink_h = 1'b1; sink_s = s[0]; sink_v = 1'b0;
    model_hdr(s);
    repeat (gap) begin
      @(negedge clk);
      sink_h = 1'b0; sink_s = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sink_h = 1'b0; sink_s = 1'b0; sink_v = 1'b1;
      sink_i = DW'(samp[k]); sink_q = DW'($urandom);
    end
    @(negedge clk);
    sink_h = 1'b0; sink_s = 1'b0; sink_v = 1'b0;
    model_end(n, gap);
    @(negedge clk);
    check_all(tag);
    @(negedge clk);
    chk({tag, ".pulse_end"}, 32'(sym_done), 32'd0);
    m_done = 0;
  endtask

  task automatic reset_dut(input string tag);
    @(negedge clk);
    reset = 1'b0;
    sink_h = 1'b0; sink_s = 1'b0; sink_v = 1'b0; sink_i = '0; sink_q = '0;
    model_reset();
    @(negedge clk);
    check_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; fft_num = 2'b00; cp_type = 1'b0;
    sink_i = '0; sink_q = '0; sink_h = 1'b0; sink_s = 1'b0; sink_v = 1'b0;
    model_reset();

    // power-on reset state
    reset_dut("reset0");

    // 2048-point, normal CP, two full slots with an impulse at sample 9
    fft_num = 2'b00; cp_type = 1'b0;
    for (int b = 0; b < 14; b++) begin
      fill(2048, 100);
      samp[9] = 16383;
      xact("n2048", (b == 0 || b == 7) ? 1 : 0, 2048, 0);
    end
    chk("t1.total",  32'(sym_total), 32'd14);
    chk("t1.pk_idx", 32'(pk_idx), PEAK ? 32'd9 : 32'd0);
    chk("t1.pk_val", 32'(pk_val), PEAK ? 32'd16383 : 32'd0);
    chk("t1.errs",   32'({len_err, hdr_err, slot_err}), 32'd0);

    // 512-point, extended CP: negative peak wins the tie, then saturation case
    reset_dut("reset1");
    fft_num = 2'b11; cp_type = 1'b1;
    for (int b = 0; b < 7; b++) begin
      fill(512, 50);
      samp[100] = -300;
      samp[200] = 300;
      if (b == 6) samp[$urandom_range(300, 511)] = -32768;
      xact("e512", (b == 0 || b == 6) ? 1 : 0, 512, 0);
      if (b == 5) begin
        chk("t2.idx5",   32'(sym_idx), 32'd5);
        chk("t2.pk_idx", 32'(pk_idx), PEAK ? 32'd100 : 32'd0);
        chk("t2.pk_val", 32'(pk_val), PEAK ? 32'd300 : 32'd0);
      end
    end
    chk("t2.wrap",  32'(sym_idx), 32'd0);
    chk("t2.sat",   32'(pk_val), PEAK ? 32'd32767 : 32'd0);
    chk("t2.errs",  32'({len_err, hdr_err, slot_err}), 32'd0);

    // short burst, good burst, then overlong burst
    reset_dut("reset2");
    fft_num = 2'b10; cp_type = 1'b0;
    fill(1024, 1000);
    xact("short1023", 1, 1023, 0);
    chk("t3.len_err", 32'(len_err), 32'd1);
    chk("t3.total0",  32'(sym_total), 32'd0);
    fill(1024, 1000);
    xact("good1024", 0, 1024, 0);
    chk("t3.total1",  32'(sym_total), 32'd1);
    fft_num = 2'b11;
    fill(513, 1000);
    xact("long513", 0, 513, 0);

    // valid two clocks after header, then recovery
    reset_dut("reset3");
    fft_num = 2'b11; cp_type = 1'b0;
    fill(512, 500);
    xact("late_v", 1, 512, 1);
    chk("t4.hdr_err", 32'(hdr_err), 32'd1);
    fill(512, 500);
    xact("recover", 0, 512, 0);

    // stray valid in IDLE
    reset_dut("reset4");
    @(negedge clk); sink_v = 1'b1;
    @(negedge clk); sink_v = 1'b0;
    m_hdr_err = 1;
    @(negedge clk);
    check_all("stray_v");

    // first header without slot start
    reset_dut("reset5");
    fft_num = 2'b11; cp_type = 1'b0;
    fill(512, 500);
    xact("first_nos", 0, 512, 0);
    chk("t5.first", 32'(slot_err), 32'd1);

    // slot start on the 5th symbol
    reset_dut("reset6");
    for (int b = 0; b < 5; b++) begin
      fill(512, 500);
      xact("early_s", (b == 0 || b == 4) ? 1 : 0, 512, 0);
    end
    chk("t5.early",  32'(slot_err), 32'd1);
    chk("t5.idx0",   32'(sym_idx), 32'd0);

    // 8th header without slot start
    reset_dut("reset7");
    for (int b = 0; b < 8; b++) begin
      fill(512, 500);
      xact("late_s", (b == 0) ? 1 : 0, 512, 0);
      if (b == 6) chk("t5.noerr7", 32'(slot_err), 32'd0);
    end
    chk("t5.late",  32'(slot_err), 32'd1);
    chk("t5.wrap",  32'(sym_idx), 32'd0);

    // asynchronous reset in the middle of a burst
    reset_dut("reset8");
    fft_num = 2'b10; cp_type = 1'b0;
    fill(1024, 2000);
    xact("pre_rst", 1, 1024, 0);
    @(negedge clk);
    sink_h = 1'b1; sink_s = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      sink_h = 1'b0; sink_s = 1'b0; sink_v = 1'b1; sink_i = DW'(samp[k]);
    end
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("mid_rst");
    @(negedge clk);
    sink_v = 1'b0; sink_i = '0;
    @(negedge clk);
    reset = 1'b1;
    fill(1024, 2000);
    xact("post_rst", 1, 1024, 0);
    chk("t6.idx",   32'(sym_idx), 32'd0);
    chk("t6.total", 32'(sym_total), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_frame_sink.md
Name: fft_frame_sink

Overview:
Receive-side counterpart of the time-domain symbol stream. It consumes the header/slot/valid framed I/Q burst stream, one burst per OFDM symbol. It checks burst length against the configured FFT size and checks slot/symbol sequencing for normal or extended CP. Per symbol it reports completion, symbol index, a running good-symbol count, sticky framing errors, and the peak |I| sample. It sits at the stream sink of the FFT datapath and doubles as a self-checking testbench monitor.

Parameters:
DATA_NBIT, 16, width of the I/Q sample words (two's complement)
CNT_NBIT, 16, width of the good-symbol counter

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-low reset
fft_num  in  2  00=2048, 01=1536, 10=1024, 11=512; sampled at each header
cp_type  in  1  0=normal CP (7 symbols/slot), 1=extended CP (6 symbols/slot); sampled at each header
sink_i  in  DATA_NBIT  in-phase sample
sink_q  in  DATA_NBIT  quadrature sample; accepted but not checked
sink_h  in  1  symbol header pulse, one clock
sink_s  in  1  slot start, only meaningful together with sink_h
sink_v  in  1  sample valid
sym_done  out  1  one-clock pulse when a correct-length burst completes
sym_idx  out  3  index within slot of the symbol just completed/in progress
sym_total  out  CNT_NBIT  count of correct-length symbols, wraps
len_err  out  1  sticky: burst length differed from fft_len
hdr_err  out  1  sticky: header/valid protocol violation
slot_err  out  1  sticky: slot-start placement violation
pk_idx  out  12  sample index (0-based) of max |I| in last completed burst
pk_val  out  DATA_NBIT  max |I| of last completed burst

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, state IDLE, internal sample counter 0, latched length 2048, sym_idx 0.
- fft_len = (4 - fft_num) * 512, 12-bit arithmetic computed from the value latched at the header. Last symbol index (last) = 6 for normal CP, 5 for extended CP.
- Protocol: sink_h is asserted for one clock. The first sink_v follows exactly one clock later. sink_v then stays high for fft_len contiguous clocks.
- States: IDLE, ARM, COLLECT.
- IDLE:
  - sink_h -> ARM; latch fft_num and cp_type.
  - sink_v without a preceding header -> set hdr_err, stay IDLE.
- ARM (one clock):
  - sink_v=1 -> COLLECT; sample counter=1; first sample is index 0.
  - sink_v=0 -> set hdr_err, go to IDLE.
  - sink_h=1 -> set hdr_err, re-latch, stay ARM.
- COLLECT:
  - sink_v=1: counter+1 while counter<fft_len. If counter would exceed fft_len, set len_err and stop counting; the burst is then treated as failed.
  - sink_v=0: if counter==fft_len, pulse sym_done next clock, increment sym_total, and update pk_idx/pk_val. Otherwise set len_err with no sym_done and no peak update. Go to IDLE in both cases.
  - sink_h while sink_v=1: set hdr_err and len_err, abandon the burst, go to ARM.
  - sink_h while sink_v=0: end-of-burst handling as above, then go directly to ARM for the new header.
- Symbol sequencing, evaluated at every accepted header:
  - sink_s=1 -> sym_idx=0. If this is not the first header since reset and the previous sym_idx != last, set slot_err.
  - sink_s=0 -> sym_idx+1. If the previous sym_idx == last, set slot_err and wrap sym_idx to 0.
  - The first header after reset with sink_s=0 sets slot_err.
- Peak detection:
  - |I| = sink_i if non-negative, else -sink_i. The most negative value saturates to 2^(DATA_NBIT-1)-1.
  - A strictly greater |I| replaces the running max and index, so ties keep the earliest index.
  - The running max and index are cleared in ARM.
- Sticky error flags clear only on reset.
- sym_done latency: one clock after the first sink_v=0 that follows the last sample.

Optional Feature:
FFT_SINK_PEAK_EN
- Defined: peak detector as described.
- Undefined: no abs/compare logic is built, and pk_idx and pk_val are constant 0. All framing checks are unchanged.

Test Plan:
- fft_num=00, cp_type=0, 14 headers with sink_s on the 1st and 8th, 2048-clock bursts, impulse I=16383 at sample 9 -> 14 sym_done pulses, sym_idx sequence 0..6 twice, sym_total=14, pk_idx=9, pk_val=16383, no error flags.
- fft_num=11, cp_type=1, 6 symbols per slot, 512-clock bursts, I=-300 at sample 100 and I=+300 at sample 200 -> pk_idx=100, pk_val=300, sym_idx wraps 5->0 on sink_s, no errors.
- fft_num=10 header followed by a 1023-clock burst -> len_err=1, no sym_done, sym_total unchanged; the next 1024-clock burst gives sym_done and sym_total+1.
- Header with sink_v delayed by 2 clocks -> hdr_err=1 and the state returns to IDLE. Stray sink_v in IDLE also gives hdr_err=1.
- Normal CP, sink_s asserted on the 5th symbol -> slot_err=1 and sym_idx=0. An 8th header without sink_s -> slot_err=1 and sym_idx wraps to 0.
- Reset asserted mid-burst at sample 500 -> all outputs 0 immediately. After release, a clean header with sink_s=1 and a full burst yield sym_done with sym_idx=0.
